store_buffer_bridge: RTL and testbench
======================================

// Module: store_buffer_bridge
// PURPOSE
//  Sits between the single-cycle CPU data port (memAdr/memWriteData/memRead/memWrite/memReadData)
//  and a handshaked data memory with multi-cycle latency. Posts CPU stores into a FIFO
//  that drains in the background. Forwards loads that hit a buffered store from the youngest
//  matching entry; misses go to memory. Raises stall, which the top level uses to freeze the CPU.
// PARAMETERS
//  DEPTH   4   store-buffer entries (power of two, >=2)
//  ADR_W   32  address width
//  DATA_W  32  data width
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  cpu_adr    in   ADR_W      CPU data address (word compare on [ADR_W-1:2])
//  cpu_wdata  in   DATA_W     CPU store data
//  cpu_read   in   1          CPU load request, level, held while stall=1
//  cpu_write  in   1          CPU store request, level, held while stall=1
//  cpu_rdata  out  DATA_W     load data, valid when cpu_read=1 and stall=0
//  stall      out  1          CPU must hold PC/state this cycle
//  mem_req    out  1          memory request, held until mem_ack
//  mem_we     out  1          1=write, 0=read; stable while mem_req
//  mem_adr    out  ADR_W      memory address; stable while mem_req
//  mem_wdata  out  DATA_W     memory write data; stable while mem_req
//  mem_rdata  in   DATA_W     memory read data, sampled on mem_ack
//  mem_ack    in   1          one-cycle completion pulse; ignored when mem_req=0
//  count      out  $clog2(DEPTH+1)  valid entries in the buffer
//  empty      out  1          count==0 and no write in flight (fence/drain-done)
// BEHAVIOUR
//  Reset (rst=0, async): count=0, head/tail=0, state=IDLE, rdata_q=0; mem_req=0, mem_we=0,
//   mem_adr=0, mem_wdata=0, stall=0, cpu_rdata=0, empty=1. Reset mid-transaction drops the
//   in-flight request and all buffered stores. Memory must tolerate req deasserting early.
//  FSM states: IDLE, DRAIN (write in flight), RD (read in flight), RD_DONE (return data).
//  Store: cpu_write=1, count<DEPTH -> entry {adr,wdata} pushed at tail on clk edge, stall=0.
//   count==DEPTH -> stall=1, no push; full test uses pre-edge count even if pop same edge.
//   No merging: repeated stores to one address each take an entry; order is preserved.
//  Load hit: cpu_read=1 and any valid entry word-address match -> cpu_rdata = data of the
//   youngest match, combinational, stall=0, no memory access.
//  Load miss: stall=1. Memory state path:
//   - IDLE -> RD: mem_req=1, mem_we=0, mem_adr=cpu_adr.
//   - RD + mem_ack: rdata_q<=mem_rdata -> RD_DONE.
//   - RD_DONE: stall=0, cpu_rdata=rdata_q -> IDLE.
//   Latency = ack cycle + 1.
//  Drain:
//   - IDLE, count>0, no load miss present -> DRAIN with head entry on mem_* (mem_we=1).
//   - On mem_ack: pop head, count-1. If count-1>0 and no load miss, stay in DRAIN with next
//     head; else -> IDLE.
//  Priority: an in-flight drain always completes first. In IDLE, a load miss beats a drain.
//  Simultaneous push+pop: count unchanged, pointers wrap mod DEPTH.
//  cpu_read&cpu_write both 1: illegal; treated as store, cpu_rdata undefined.
//  mem_adr/mem_wdata driven 0 whenever mem_req=0.
// TESTING
//  1 Store 0x100<-0xAAAA_0001, no ack -> count=1, stall=0, mem_req=1 we=1 adr=0x100; ack -> count=0, empty=1.
//  2 Stores 0x200<-1 then 0x200<-2, load 0x200 before drain -> cpu_rdata=2, stall=0, no mem read.
//  3 Hold mem_ack=0, issue 5 stores (DEPTH=4) -> 5th sees stall=1 until first ack, then accepted.
//  4 Load miss 0x300, ack after 3 cycles with 0xDEAD_BEEF -> stall=1 for 4 cycles, data=0xDEADBEEF next cycle.
//  5 Drain in flight + load miss -> drain ack first, then read req; no entry lost, order kept.
//  6 rst low mid-DRAIN with count=3 -> immediately mem_req=0, count=0, stall=0, empty=1.

Source files
------------

// File: rtl/store_buffer_bridge.sv
// Posted-store FIFO bridge between a single-cycle CPU data port and a handshaked,
// multi-cycle data memory. Loads forward from the youngest matching buffered store.
module store_buffer_bridge #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADR_W  = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADR_W-1:0]           cpu_adr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       cpu_read,
  input  logic                       cpu_write,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADR_W-1:0]           mem_adr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StDrain, StRd, StRdDone} state_e;

  state_e              state_q, state_d;
  logic [ADR_W-1:0]    adr_q  [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADR_W-1:0]    rd_adr_q, rd_adr_d;

  logic                full, push, pop, hit, load_miss;
  logic [DATA_W-1:0]   hit_data;
  logic [PtrW-1:0]     idx;

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (adr_q[idx][ADR_W-1:2] == cpu_adr[ADR_W-1:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign full      = (count_q == CntFull);
  assign push      = cpu_write & ~full;
  assign load_miss = cpu_read & ~cpu_write & ~hit;
  assign pop       = (state_q == StDrain) & mem_ack;

  always_comb begin
    head_d  = pop  ? head_q + PtrW'(1) : head_q;
    tail_d  = push ? tail_q + PtrW'(1) : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rd_adr_d = rd_adr_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        // A pending load miss wins over starting a new drain.
        if (load_miss) begin
          state_d  = StRd;
          rd_adr_d = cpu_adr;
        end else if (count_q != '0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_ack) begin
          state_d = ((count_q > CntW'(1)) && !load_miss) ? StDrain : StIdle;
        end
      end
      StRd: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = StRdDone;
        end
      end
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    unique case (state_q)
      StDrain: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = adr_q[head_q];
        mem_wdata = data_q[head_q];
      end
      StRd: begin
        mem_req = 1'b1;
        mem_adr = rd_adr_q;
      end
      default: ;
    endcase

    stall     = (cpu_write & full) | (load_miss & (state_q != StRdDone));
    cpu_rdata = '0;
    if (state_q == StRdDone) begin
      cpu_rdata = rdata_q;
    end else if (cpu_read & hit) begin
      cpu_rdata = hit_data;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0) && (state_q != StDrain);

  // Entry storage needs no reset: count_q gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail_q]  <= cpu_adr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rd_adr_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rd_adr_q <= rd_adr_d;
    end
  end

endmodule

// File: tb/tb_store_buffer_bridge.sv
// Bench for store_buffer_bridge: directed scenarios then random loads/stores, checked
// against an architectural memory view plus an in-order queue of posted stores.
module tb_store_buffer_bridge;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic [2:0]  count;
  logic        empty;

  store_buffer_bridge #(.DEPTH(DEPTH), .ADR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] adr; logic [31:0] data;} st_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  st_t         exp_q[$];          // stores accepted but not yet written to memory
  logic [31:0] arch [int];        // what the CPU should observe, by word index
  logic [31:0] phys [int];        // what the memory actually holds, by word index
  logic [32:0] log_q[$];          // completed memory transactions {we, adr}
  int          ack_delay = 1;
  int          hold_cnt  = 0;
  int          wait_cnt  = 0;
  int          n_reads   = 0;
  bit          pend_pop  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    int w;
    w = int'(a >> 2);
    return arch.exists(w) ? arch[w] : init_val(w);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    int w;
    w = int'(a >> 2);
    return phys.exists(w) ? phys[w] : init_val(w);
  endfunction

  function automatic bit buffered(input logic [31:0] a);
    foreach (exp_q[i]) if (exp_q[i].adr[31:2] == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // Memory responder: acks after ack_delay request cycles, unless held.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (pend_pop) begin
        void'(exp_q.pop_front());
        pend_pop = 0;
      end
      if (!rst) begin
        wait_cnt = 0;
      end else if (!mem_req) begin
        wait_cnt = 0;
        check("idle_bus_adr_data", {mem_adr, mem_wdata}, 64'd0);
        check("idle_bus_we", mem_we, 1'b0);
      end else begin
        if (!mem_we) n_reads++;
        if (hold_cnt > 0) begin
          hold_cnt--;
        end else begin
          wait_cnt++;
          if (wait_cnt >= ack_delay) begin
            wait_cnt = 0;
            mem_ack  = 1'b1;
            log_q.push_back({mem_we, mem_adr});
            if (mem_we) begin
              check("drain_has_entry", exp_q.size() > 0, 1'b1);
              if (exp_q.size() > 0) begin
                check("drain_adr", mem_adr, exp_q[0].adr);
                check("drain_data", mem_wdata, exp_q[0].data);
                pend_pop = 1;
              end
              phys[int'(mem_adr >> 2)] = mem_wdata;
            end else begin
              mem_rdata = phys_rd(mem_adr);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    bit done;
    done   = 0;
    stalls = 0;
    cpu_adr = a; cpu_wdata = d; cpu_write = 1'b1; cpu_read = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      check("store_count", count, exp_q.size());
      check("store_stall", stall, exp_q.size() == DEPTH);
      if (exp_q.size() < DEPTH) done = 1;
      else stalls++;
    end
    if (!done) check("store_timeout", done, 1'b1);
    step();
    if (done) begin
      exp_q.push_back(st_t'{adr: a, data: d});
      arch[int'(a >> 2)] = d;
    end
    cpu_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls);
    logic [31:0] expd;
    bit          in_buf;
    int          rd0;
    stalls = 0;
    cpu_adr = a; cpu_read = 1'b1; cpu_write = 1'b0;
    @(negedge clk);
    expd   = arch_rd(a);
    in_buf = buffered(a);
    rd0    = n_reads;
    while (stall === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 100) check("load_timeout", stall, 1'b0);
    check("load_data", cpu_rdata, expd);
    check("load_stalled_iff_miss", stalls > 0, !in_buf);
    step();
    cpu_read = 1'b0;
    if (in_buf) begin
      @(negedge clk);
      check("hit_no_mem_read", n_reads - rd0, 0);
      step();
    end
  endtask

  task automatic wait_empty();
    int i;
    i = 0;
    while (!(empty === 1'b1 && exp_q.size() == 0) && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("drain_empty", empty, 1'b1);
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_count", count, 3'd0);
    step();
  endtask

  initial begin
    int s, tot;
    logic [31:0] a;
    rst = 1'b1; cpu_adr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_count", count, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_adr", mem_adr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // 1: single store posted, then drained
    hold_cnt = 1000;
    do_store(32'h100, 32'hAAAA_0001, s);
    @(negedge clk);
    check("t1_count", count, 3'd1);
    check("t1_stall", stall, 1'b0);
    @(negedge clk);
    check("t1_mem_req", mem_req, 1'b1);
    check("t1_mem_we", mem_we, 1'b1);
    check("t1_mem_adr", mem_adr, 32'h100);
    check("t1_mem_wdata", mem_wdata, 32'hAAAA_0001);
    step();
    hold_cnt = 0;
    wait_empty();

    // 2: repeated stores to one word, load forwards the youngest
    hold_cnt = 1000;
    do_store(32'h200, 32'd1, s);
    do_store(32'h200, 32'd2, s);
    do_load(32'h200, s);
    check("t2_hit_stalls", s, 0);
    hold_cnt = 0;
    wait_empty();

    // 3: fifth store stalls on a full buffer until the first drain completes
    ack_delay = 1;
    hold_cnt  = 6;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h800 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), s);
      tot += s;
    end
    check("t3_first_four_no_stall", tot, 0);
    do_store(32'h810, 32'hC0DE_0004, s);
    check("t3_fifth_stalled", s > 0, 1'b1);
    wait_empty();

    // 4: load miss with ack three cycles in
    ack_delay = 3;
    do_load(32'h300, s);
    check("t4_stall_cycles", s, 4);
    phys[int'(32'h304 >> 2)] = 32'hDEAD_BEEF;
    arch[int'(32'h304 >> 2)] = 32'hDEAD_BEEF;
    do_load(32'h304, s);
    check("t4_stall_cycles_b", s, 4);

    // 5: drain in flight when a load miss arrives
    wait_empty();
    log_q.delete();
    hold_cnt = 1000;
    do_store(32'h400, 32'h11, s);
    do_store(32'h404, 32'h22, s);
    for (int i = 0; i < 10 && mem_req !== 1'b1; i++) @(negedge clk);
    check("t5_drain_started", mem_req, 1'b1);
    step();
    ack_delay = 2;
    hold_cnt  = 0;
    do_load(32'h500, s);
    wait_empty();
    check("t5_log_size", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t5_log0", log_q[0], {1'b1, 32'h400});
      check("t5_log1", log_q[1], {1'b0, 32'h500});
      check("t5_log2", log_q[2], {1'b1, 32'h404});
    end

    // 6: reset while draining with three entries buffered
    hold_cnt = 1000;
    do_store(32'h600, 32'h61, s);
    do_store(32'h604, 32'h62, s);
    do_store(32'h608, 32'h63, s);
    for (int i = 0; i < 10 && mem_req !== 1'b1; i++) @(negedge clk);
    check("t6_drain_started", mem_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    arch     = phys;
    pend_pop = 0;
    hold_cnt = 0;
    #1;
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_count", count, 3'd0);
    check("t6_stall", stall, 1'b0);
    check("t6_empty", empty, 1'b1);
    check("t6_mem_adr", mem_adr, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Random mix over a small address window so forwarding hits are common
    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      ack_delay = int'($urandom_range(1, 4));
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      if (r < 5) begin
        do_store(a, $urandom, s);
      end else if (r < 9) begin
        do_load(a + 32'($urandom_range(0, 3)), s);
      end else begin
        step();
      end
    end
    wait_empty();
    for (int k = 0; k < 8; k++) begin
      a = 32'h1000 + 32'(4 * k);
      check("final_mem", phys_rd(a), arch_rd(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
